// File: rtl/sram_arbiter_if.sv
// Two-port SRAM arbiter bus: both requester ports, the SRAM controller
// side and the grant vector, seen from the arbiter (master) or its peers.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_wr_en;
  logic              p0_rd_en;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_ready;

  logic              p1_wr_en;
  logic              p1_rd_en;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_ready;

  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [1:0]        gnt;

  modport master (
    input  p0_wr_en, p0_rd_en, p0_addr, p0_wdata,
    output p0_rdata, p0_ready,
    input  p1_wr_en, p1_rd_en, p1_addr, p1_wdata,
    output p1_rdata, p1_ready,
    output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output gnt
  );

  modport slave (
    output p0_wr_en, p0_rd_en, p0_addr, p0_wdata,
    input  p0_rdata, p0_ready,
    output p1_wr_en, p1_rd_en, p1_addr, p1_wdata,
    input  p1_rdata, p1_ready,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  gnt
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: IDLE/ISSUE/WAIT/DONE, one transaction in flight.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  sram_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic req0, req1, pick1, act;

  assign req0 = bus.p0_wr_en | bus.p0_rd_en;
  assign req1 = bus.p1_wr_en | bus.p1_rd_en;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // last1_q=1: port 1 owned the bus last
  logic last1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last1_q <= 1'b1;
    end else if (state_q == IDLE && (req0 | req1)) begin
      last1_q <= pick1;
    end
  end

  assign pick1 = req1 & (~req0 | ~last1_q);
`else
  assign pick1 = req1 & ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ISSUE;
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          wr_d    = pick1 ? bus.p1_wr_en : bus.p0_wr_en;
          addr_d  = pick1 ? bus.p1_addr : bus.p0_addr;
          wdata_d = pick1 ? bus.p1_wdata : bus.p0_wdata;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.mem_ready) begin
          state_d = DONE;
          if (!wr_q) rdata_d = bus.mem_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign act = (state_q == ISSUE) | (state_q == WAIT);

  assign bus.mem_wr_en = act & wr_q;
  assign bus.mem_rd_en = act & ~wr_q;
  assign bus.mem_addr  = act ? addr_q : '0;
  assign bus.mem_wdata = act ? wdata_q : '0;
  assign bus.gnt       = gnt_q;
  assign bus.p0_rdata  = rdata_q;
  assign bus.p1_rdata  = rdata_q;

  // The owner stays not-ready while its transaction is in flight,
  // even if it drops its request, so DONE is its only ready pulse.
  always_comb begin
    bus.p0_ready = ~req0;
    bus.p1_ready = ~req1;
    if (state_q == DONE) begin
      if (gnt_q[0]) bus.p0_ready = 1'b1;
      if (gnt_q[1]) bus.p1_ready = 1'b1;
    end else if (act) begin
      if (gnt_q[0]) bus.p0_ready = 1'b0;
      if (gnt_q[1]) bus.p1_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model plus an ordered scoreboard of
// expected grants and read data, one task per scenario.
module tb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  g;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int lat = 1;

  logic [31:0] mem [logic [31:0]];

  // SRAM controller model: ready after lat+1 cycles of request
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_wr_en | bus.mem_rd_en) begin
        cnt++;
        bus.mem_ready = (cnt > lat);
        bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : '0;
        if (bus.mem_ready && bus.mem_wr_en)
          mem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int p, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.p0_wr_en = wr;
      bus.p0_rd_en = rd;
      bus.p0_addr  = a;
      bus.p0_wdata = d;
    end else begin
      bus.p1_wr_en = wr;
      bus.p1_rd_en = rd;
      bus.p1_addr  = a;
      bus.p1_wdata = d;
    end
  endtask

  function automatic logic is_done();
    return bus.gnt != 2'b00 && !bus.mem_wr_en && !bus.mem_rd_en;
  endfunction

  // Observe only: step negedges until DONE or the budget expires.
  task automatic watch(input int max_cyc, output int ncyc,
                       output int rdy_cyc, output bit ok);
    ncyc = 0;
    rdy_cyc = -1;
    ok = 1'b0;
    while (!ok && ncyc < max_cyc) begin
      @(negedge clk);
      ncyc++;
      if (is_done()) ok = 1'b1;
      else if (bus.mem_ready && (bus.mem_wr_en | bus.mem_rd_en))
        rdy_cyc = ncyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.mem_wr_en, bus.mem_rd_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got gnt=%b wr=%b rd=%b, want 0",
               bus.gnt, bus.mem_wr_en, bus.mem_rd_en);
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.p0_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, want 0",
               bus.mem_addr, bus.mem_wdata, bus.p0_rdata);
    end
    checks++;
    if ({bus.p0_ready, bus.p1_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b%b, want 11",
               bus.p0_ready, bus.p1_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_p0();
    int n, r;
    bit ok;
    exp_t e;
    lat = 1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h400, 32'hDEAD_BEEF);
    sb.push_back('{2'b01, 1'b1, 32'h400, 32'hDEAD_BEEF, 32'h0});
    #1;
    checks++;
    if (bus.p0_ready !== 1'b0 || bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL wr_idle: got rdy=%b gnt=%b, want 0 00",
               bus.p0_ready, bus.gnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.mem_wr_en, bus.mem_rd_en} !== 4'b0110 ||
        bus.mem_addr !== sb[0].addr || bus.mem_wdata !== sb[0].wdata) begin
      errors++;
      $display("FAIL wr_issue: got gnt=%b wr=%b rd=%b a=%h d=%h, want 01 1 0 %h %h",
               bus.gnt, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr,
               bus.mem_wdata, sb[0].addr, sb[0].wdata);
    end
    watch(20, n, r, ok);
    checks++;
    if (!ok || n != 2 || r != n - 1) begin
      errors++;
      $display("FAIL wr_latency: got done=%0d n=%0d rdy=%0d, want 1 2 1",
               ok, n, r);
    end
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (bus.gnt !== e.g || {bus.p0_ready, bus.p1_ready} !== 2'b11) begin
      errors++;
      $display("FAIL wr_done: got gnt=%b rdy=%b%b, want %b 11",
               bus.gnt, bus.p0_ready, bus.p1_ready, e.g);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.mem_wr_en, bus.mem_rd_en} !== 4'b0000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.p0_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_after: got gnt=%b a=%h d=%h rdy=%b, want idle",
               bus.gnt, bus.mem_addr, bus.mem_wdata, bus.p0_ready);
    end
    checks++;
    if (!mem.exists(32'h400) || mem[32'h400] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_mem: got %h, want deadbeef",
               mem.exists(32'h400) ? mem[32'h400] : 32'hx);
    end
  endtask

  task automatic test_write_read();
    int n, r;
    bit ok;
    exp_t e;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h404, 32'h1234_5678);
    sb.push_back('{2'b01, 1'b1, 32'h404, 32'h1234_5678, 32'h0});
    watch(20, n, r, ok);
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (!ok || bus.gnt !== e.g) begin
      errors++;
      $display("FAIL wrrd_write: got done=%0d gnt=%b, want 1 %b",
               ok, bus.gnt, e.g);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'h404, '0);
    sb.push_back('{2'b10, 1'b0, 32'h404, 32'h0, 32'h1234_5678});
    watch(20, n, r, ok);
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (!ok || bus.gnt !== e.g || bus.p1_ready !== 1'b1 ||
        bus.p1_rdata !== e.rdata || bus.p0_rdata !== e.rdata) begin
      errors++;
      $display("FAIL wrrd_read: got done=%0d gnt=%b rdy=%b rd1=%h rd0=%h, want %b 1 %h",
               ok, bus.gnt, bus.p1_ready, bus.p1_rdata, bus.p0_rdata,
               e.g, e.rdata);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.p1_rdata !== e.rdata || bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL wrrd_hold: got rd=%h gnt=%b, want %h 00",
               bus.p1_rdata, bus.gnt, e.rdata);
    end
  endtask

  task automatic test_arbitration();
    int n, r;
    bit ok;
    exp_t e;
    logic [1:0] order [5];
    mem[32'h500] = 32'hA5A5_0000;
    mem[32'h600] = 32'h5A5A_1111;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
`else
    order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 32'h500, '0);
    drive(1, 1'b0, 1'b1, 32'h600, '0);
    for (int i = 0; i < 5; i++)
      sb.push_back('{order[i], 1'b0, order[i][0] ? 32'h500 : 32'h600, 32'h0,
                     order[i][0] ? 32'hA5A5_0000 : 32'h5A5A_1111});
    for (int i = 0; i < 5; i++) begin
      watch(20, n, r, ok);
      if (sb.size() > 0) e = sb.pop_front();
      checks++;
      if (!ok || bus.gnt !== e.g || bus.p0_rdata !== e.rdata ||
          bus.p1_rdata !== e.rdata) begin
        errors++;
        $display("FAIL arb_%0d: got done=%0d gnt=%b rd=%h, want %b %h",
                 i, ok, bus.gnt, bus.p0_rdata, e.g, e.rdata);
      end
      if (i <= 3) begin
        checks++;
        if ((e.g[0] ? bus.p1_ready : bus.p0_ready) !== 1'b0) begin
          errors++;
          $display("FAIL arb_pending_%0d: got loser ready=1, want 0", i);
        end
      end
      if (i == 3) drive(0, 1'b0, 1'b0, '0, '0);
      if (i == 4) drive(1, 1'b0, 1'b0, '0, '0);
    end
    @(negedge clk);
  endtask

  task automatic test_wr_rd_both();
    int n;
    bit ok;
    exp_t e;
    lat = 2;
    n = 0;
    ok = 1'b0;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h408, 32'hCAFE_F00D);
    sb.push_back('{2'b10, 1'b1, 32'h408, 32'hCAFE_F00D, 32'h0});
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (is_done()) ok = 1'b1;
      else begin
        checks++;
        if (bus.mem_wr_en !== 1'b1 || bus.mem_rd_en !== 1'b0 ||
            bus.mem_addr !== sb[0].addr) begin
          errors++;
          $display("FAIL both_op_%0d: got wr=%b rd=%b a=%h, want 1 0 %h",
                   n, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, sb[0].addr);
        end
      end
    end
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (!ok || bus.gnt !== e.g || bus.p1_ready !== 1'b1) begin
      errors++;
      $display("FAIL both_done: got done=%0d gnt=%b rdy=%b, want 1 %b 1",
               ok, bus.gnt, bus.p1_ready, e.g);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (!mem.exists(32'h408) || mem[32'h408] !== e.wdata) begin
      errors++;
      $display("FAIL both_mem: got %h, want %h",
               mem.exists(32'h408) ? mem[32'h408] : 32'hx, e.wdata);
    end
  endtask

  task automatic test_reset_mid();
    int n, r;
    bit ok;
    exp_t e;
    lat = 8;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h500, '0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_wait: got rd=%b gnt=%b, want 1 01",
               bus.mem_rd_en, bus.gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.gnt, bus.mem_wr_en, bus.mem_rd_en} !== 4'b0000 ||
        bus.mem_addr !== '0 || bus.p0_ready !== 1'b0 || bus.p0_rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_abort: got gnt=%b wr=%b rd=%b a=%h rdy=%b rd=%h, want idle",
               bus.gnt, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr,
               bus.p0_ready, bus.p0_rdata);
    end
    // the aborted read never reaches the scoreboard; only the retry does
    lat = 1;
    sb.push_back('{2'b01, 1'b0, 32'h500, 32'h0, mem[32'h500]});
    watch(20, n, r, ok);
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (!ok || bus.gnt !== e.g || bus.p0_ready !== 1'b1 ||
        bus.p0_rdata !== e.rdata) begin
      errors++;
      $display("FAIL rstmid_retry: got done=%0d gnt=%b rdy=%b rd=%h, want %b 1 %h",
               ok, bus.gnt, bus.p0_ready, bus.p0_rdata, e.g, e.rdata);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_deassert();
    int n, dn;
    bit ok;
    exp_t e;
    lat = 3;
    n = 0;
    dn = 0;
    ok = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h40C, 32'h0BAD_CAFE);
    sb.push_back('{2'b01, 1'b1, 32'h40C, 32'h0BAD_CAFE, 32'h0});
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'hFFFF_0000, 32'h1);
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (is_done()) ok = 1'b1;
      else begin
        checks++;
        if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== sb[0].addr ||
            bus.mem_wdata !== sb[0].wdata) begin
          errors++;
          $display("FAIL deassert_hold_%0d: got wr=%b a=%h d=%h, want 1 %h %h",
                   n, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata,
                   sb[0].addr, sb[0].wdata);
        end
      end
    end
    if (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (!ok || bus.gnt !== e.g || bus.p0_ready !== 1'b1) begin
      errors++;
      $display("FAIL deassert_done: got done=%0d gnt=%b rdy=%b, want 1 %b 1",
               ok, bus.gnt, bus.p0_ready, e.g);
    end
    repeat (4) begin
      @(negedge clk);
      if (is_done() || bus.mem_wr_en || bus.mem_rd_en) dn++;
    end
    checks++;
    if (dn != 0 || mem[32'h40C] !== e.wdata) begin
      errors++;
      $display("FAIL deassert_once: got extra=%0d mem=%h, want 0 %h",
               dn, mem[32'h40C], e.wdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_write_read();
    test_arbitration();
    test_wr_rd_both();
    test_reset_mid();
    test_deassert();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
